mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage access controller between the EX/MEM pipeline register and `data_memory`. It accepts one load/store request at a time and drives `data_memory`'s word-wide address, data and enable ports. It adds byte and halfword loads (sign- and zero-extended) and byte and halfword stores, done as read-modify-write. Misaligned accesses are flagged without touching memory.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, word width (fixed at 32; other values unsupported)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request this cycle
- `req_op`  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data (low byte/half used for SB/SH)
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  32  load result, extended; 0 for stores and errors
- `rsp_err`  out  1  misaligned access, valid with `rsp_valid`
- `mem_addr`  out  32  to `data_memory` address, word aligned ([1:0]=0)
- `mem_wdata`  out  32  to `data_memory` dataIn
- `mem_write_en`  out  1  to `data_memory` write_en
- `mem_read_en`  out  1  to `data_memory` read_en
- `mem_rdata`  in  32  from `data_memory` mem_out

## Operation
- `data_memory` is word-addressed by byte address. Its read is synchronous: `mem_rdata` is valid in the cycle after the cycle in which `mem_read_en` is high. Its write commits at the clock edge that ends a cycle with `mem_write_en` high.
- Byte lanes are little-endian: lane k = `addr[1:0]` selects bits [8k+7:8k]; halfword at `addr[1]` selects [16h+15:16h].
- Handshake: a request is accepted on a rising edge with `req_valid && req_ready`. At acceptance the unit registers op, addr, wdata and lane. `req_ready` = (state == IDLE).
- Misalignment is checked at acceptance: LW/SW need `addr[1:0]`≠0 to fail; LH/LHU/SH fail on `addr[0]`=1. A failing request performs no memory access and returns to IDLE with `rsp_err`=1.
- FSM states:
  - IDLE
  - RD: `mem_read_en`=1
  - RD_WAIT: extract and extend `mem_rdata`
  - WR: `mem_write_en`=1, `mem_wdata`=`req_wdata`
  - RMW_RD: `mem_read_en`=1
  - RMW_WR: `mem_write_en`=1, `mem_wdata` = `mem_rdata` with the selected lane(s) replaced; the merge is combinational from `mem_rdata`
- FSM transitions:
  - IDLE→RD for loads, →WR for SW, →RMW_RD for SH/SB
  - RD→RD_WAIT→IDLE
  - WR→IDLE
  - RMW_RD→RMW_WR→IDLE
- `rsp_valid`, `rsp_rdata` and `rsp_err` are registered. They pulse for the single cycle after the final state, and that cycle is IDLE.
- `mem_addr` = registered `{addr[31:2],2'b00}` in every non-IDLE state, 0 in IDLE. Enables are 0 outside the states listed above.

## Timing
- Acceptance at edge ending cycle N.
- Load: `mem_read_en` in N+1, `rsp_valid` in N+3.
- SW: `mem_write_en` in N+1, `rsp_valid` in N+2.
- SH/SB: `mem_read_en` in N+1, `mem_write_en` in N+2, `rsp_valid` in N+3.
- Misaligned: `rsp_valid`+`rsp_err` in N+1.
- Back-to-back: a request may be accepted in the same IDLE cycle in which `rsp_valid` pulses.
- Reset: while `rst`=0, state=IDLE. All outputs are 0 except `req_ready`=1. Assertion mid-operation aborts immediately and asynchronously. No write occurs unless its committing edge preceded reset, so an RMW interrupted in RMW_RD leaves memory unchanged.
- `req_*` inputs are ignored while `req_ready`=0.

## Structure
- Package `mem_access_pkg`: op encodings (`OP_LW`…`OP_SB`), FSM state enum, `is_load`/`is_sub_word` helper functions.
- Sub-module `load_store_align` (combinational): load extract/extend from word + lane + op, and store merge of old word + new data + lane + op. Instantiated once.
- The FSM, request registers and response registers live in `mem_access_unit`.

## Test plan
- SW 1124 ← 100: `mem_write_en` for one cycle at N+1 with `mem_addr` 1124 and `mem_wdata` 100, `rsp_valid` N+2, `rsp_err` 0. Then LW 1124: `rsp_rdata`=100 at N+3.
- Word 1124 = 0x11223344, SB 1125 data 0xAB: written word 0x1122AB44. LBU 1125 → 0x000000AB; LB 1125 → 0xFFFFFFAB.
- Word 1124 = 0x80001234: LH 1126 → 0xFFFF8000, LHU 1126 → 0x00008000, LH 1124 → 0x00001234.
- LW 1125 and SH 1127: `rsp_err`=1 at N+1, `rsp_rdata`=0, no read/write enable ever asserted.
- `rst` low during RMW_RD of SB 1124: `mem_write_en` never asserts, outputs 0, `req_ready`=1, memory word unchanged.
- `req_valid` held high with LW then SW: second request accepted in the first request's `rsp_valid` cycle, and no idle gap beyond FSM latency.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: op encodings, FSM states and decode helpers for mem_access_unit
package mem_access_pkg;
  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_WAIT, S_WR, S_RMW_RD, S_RMW_WR} state_t;
  function automatic logic is_load(input logic [2:0] op);
    return op <= OP_LBU;
  endfunction
  function automatic logic is_sub_word(input logic [2:0] op);
    return op == OP_SH || op == OP_SB;
  endfunction
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
    return (op == OP_LW || op == OP_SW) ? |lane :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? lane[0] : 1'b0;
  endfunction
endpackage

// File: rtl/load_store_align.sv
// load_store_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module load_store_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);
  logic [31:0] shifted;
  logic [31:0] bmask;
  logic [31:0] hmask;
  logic [7:0]  b;
  logic [15:0] h;
  assign shifted = word >> {lane, 3'b000};
  assign b       = shifted[7:0];
  assign h       = lane[1] ? word[31:16] : word[15:0];
  assign bmask   = 32'h0000_00ff << {lane, 3'b000};
  assign hmask   = lane[1] ? 32'hffff_0000 : 32'h0000_ffff;
  assign rdata   = op == OP_LW  ? word :
                   op == OP_LH  ? {{16{h[15]}}, h} :
                   op == OP_LHU ? {16'h0, h} :
                   op == OP_LB  ? {{24{b[7]}}, b} :
                   op == OP_LBU ? {24'h0, b} : '0;
  assign merged  = op == OP_SB ? (word & ~bmask) | ({4{wdata[7:0]}} & bmask) :
                   op == OP_SH ? (word & ~hmask) | ({2{wdata[15:0]}} & hmask) : wdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-request load/store controller for a word-wide synchronous data_memory
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t            state, next;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] merged;
  logic              accept;
  logic              bad;
  assign accept = req_valid && req_ready;
  assign bad    = misaligned(req_op, req_addr[1:0]);
  load_store_align u_align (
    .op    (op),
    .lane  (addr[1:0]),
    .word  (mem_rdata),
    .wdata (wdata),
    .rdata (ld_data),
    .merged(merged)
  );
  always_comb begin
    next         = state;
    req_ready    = state == S_IDLE;
    mem_read_en  = state == S_RD || state == S_RMW_RD;
    mem_write_en = state == S_WR || state == S_RMW_WR;
    mem_addr     = state != S_IDLE ? {addr[ADDR_W-1:2], 2'b00} : '0;
    mem_wdata    = state == S_WR ? wdata : state == S_RMW_WR ? merged : '0;
    next         = state == S_IDLE   ? (accept && !bad ? (is_load(req_op) ? S_RD :
                                                          is_sub_word(req_op) ? S_RMW_RD : S_WR) : S_IDLE) :
                   state == S_RD     ? S_RD_WAIT :
                   state == S_RMW_RD ? S_RMW_WR : S_IDLE;
  end
  // misaligned requests respond straight from IDLE without entering any memory state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op        <= '0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= next;
      if (accept) begin
        op    <= req_op;
        addr  <= req_addr;
        wdata <= req_wdata;
      end
      rsp_valid <= (accept && bad) || state == S_RD_WAIT || state == S_WR || state == S_RMW_WR;
      rsp_err   <= accept && bad;
      rsp_rdata <= state == S_RD_WAIT ? ld_data : '0;
    end
  end
endmodule
